// File: rtl/newtag_issuer.sv
// Round-robin tag issuer: keeps a free/busy bitmap, stages one free tag on a valid/ready
// output and takes tags back on a retire port. Define NEWTAG_ISSUER_CNT_EN for out_cnt.
module newtag_issuer #(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             tag_valid,
  input  logic             tag_ready,
  output logic [TAG_W-1:0] tag,
  input  logic             ret_valid,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             all_busy,
  output logic             err
`ifdef NEWTAG_ISSUER_CNT_EN
  ,
  output logic [TAG_W:0]   out_cnt
`endif
);

  localparam int NT = 1 << TAG_W;

  // Handshake: a tag transfers on a cycle where tag_valid & tag_ready are both 1;
  // tag_valid never drops and tag never changes until that transfer happens.
  typedef enum logic {ST_EMPTY = 1'b0, ST_STAGED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [NT-1:0]    busy_q, busy_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic             all_busy_q, all_busy_d;
  logic             err_q, err_d;

  logic             hs;
  logic             take;
  logic             found;
  logic [TAG_W-1:0] found_tag;
  logic             ret_staged;
  logic             ret_ok;
  logic             ret_bad;

  // Scan from highest offset down so the last hit is the nearest free tag at/after ptr.
  always_comb begin
    found     = 1'b0;
    found_tag = ptr_q;
    for (int i = NT - 1; i >= 0; i--) begin
      if (!busy_q[ptr_q + TAG_W'(i)]) begin
        found     = 1'b1;
        found_tag = ptr_q + TAG_W'(i);
      end
    end
  end

  assign hs         = (state_q == ST_STAGED) && tag_ready;
  assign take       = (state_q == ST_EMPTY) || hs;
  assign ret_staged = (state_q == ST_STAGED) && (ret_tag == tag_q);
  assign ret_ok     = ret_valid && busy_q[ret_tag] && !ret_staged;
  assign ret_bad    = ret_valid && !ret_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:  if (found) state_d = ST_STAGED;
      ST_STAGED: if (hs && !found) state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    tag_valid = (state_q == ST_STAGED);
    tag       = tag_q;
    all_busy  = all_busy_q;
    err       = err_q;
  end

  // The newly staged tag is always FREE in busy_q, so it can never collide with a retire.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    ptr_d  = ptr_q;
    if (ret_ok) begin
      busy_d[ret_tag] = 1'b0;
    end
    if (take && found) begin
      busy_d[found_tag] = 1'b1;
      tag_d             = found_tag;
      ptr_d             = found_tag + TAG_W'(1);
    end
    all_busy_d = &busy_d;
    err_d      = err_q | ret_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      tag_q      <= '0;
      ptr_q      <= '0;
      all_busy_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      tag_q      <= tag_d;
      ptr_q      <= ptr_d;
      all_busy_q <= all_busy_d;
      err_q      <= err_d;
    end
  end

`ifdef NEWTAG_ISSUER_CNT_EN
  logic [TAG_W:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({hs, ret_ok})
      2'b10:   cnt_d = cnt_q + (TAG_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (TAG_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_newtag_issuer.sv
// Bench for newtag_issuer: directed scenarios plus a randomized run, all checked against
// a per-tag lifecycle model (FREE/STAGED/OUTSTANDING) kept in this file.
module tb_newtag_issuer;

  localparam int TAG_W = 3;
  localparam int NT    = 1 << TAG_W;
  localparam int L_FREE = 0;
  localparam int L_STAGED = 1;
  localparam int L_OUT = 2;

  logic             clk;
  logic             rst_n;
  logic             tag_valid;
  logic             tag_ready;
  logic [TAG_W-1:0] tag;
  logic             ret_valid;
  logic [TAG_W-1:0] ret_tag;
  logic             all_busy;
  logic             err;
`ifdef NEWTAG_ISSUER_CNT_EN
  logic [TAG_W:0]   out_cnt;
`endif

  int tests_run;
  int tests_failed;

  newtag_issuer #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_valid (tag_valid),
    .tag_ready (tag_ready),
    .tag       (tag),
    .ret_valid (ret_valid),
    .ret_tag   (ret_tag),
    .all_busy  (all_busy),
    .err       (err)
`ifdef NEWTAG_ISSUER_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: lifecycle of every tag plus the round-robin pointer
  int life[NT];
  int m_tag;
  int m_ptr;
  int m_cnt;
  bit m_valid;
  bit m_err;
  bit m_all_busy;

  logic [TAG_W+2:0] obs;
  assign obs = {tag_valid, tag, all_busy, err};

  function automatic logic [TAG_W+2:0] exp_obs();
    return {m_valid, TAG_W'(m_tag), m_all_busy, m_err};
  endfunction

  task automatic model_reset();
    foreach (life[k]) life[k] = L_FREE;
    m_tag = 0; m_ptr = 0; m_cnt = 0;
    m_valid = 0; m_err = 0; m_all_busy = 0;
  endtask

  task automatic model_edge();
    int pre[NT];
    bit hs;
    bit fnd;
    int j;
    pre = life;
    hs = m_valid && tag_ready;
    if (ret_valid) begin
      if (pre[ret_tag] == L_OUT) begin
        life[ret_tag] = L_FREE;
        m_cnt--;
      end else begin
        m_err = 1;
      end
    end
    if (hs) begin
      life[m_tag] = L_OUT;
      m_cnt++;
    end
    if (!m_valid || hs) begin
      fnd = 0;
      for (int k = 0; k < NT; k++) begin
        j = (m_ptr + k) % NT;
        if (!fnd && pre[j] == L_FREE) begin
          fnd = 1;
          life[j] = L_STAGED;
          m_tag = j;
          m_ptr = (j + 1) % NT;
        end
      end
      m_valid = fnd;
    end
    m_all_busy = 1;
    foreach (life[k]) if (life[k] == L_FREE) m_all_busy = 0;
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tag_ready = 1'b0;
    ret_valid = 1'b0;
    ret_tag = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
`ifdef NEWTAG_ISSUER_CNT_EN
    tests_run++;
    if (out_cnt !== 0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %0d want 0", out_cnt);
    end
`endif
    cycle();
    tests_run++;
    if (tag_valid !== 1'b1 || tag !== 0) begin
      tests_failed++;
      $display("FAIL first_tag: got valid=%b tag=%0d want valid=1 tag=0", tag_valid, tag);
    end
  endtask

  task automatic test_fill();
    tag_ready = 1'b1;
    for (int k = 0; k < NT; k++) begin
      tests_run++;
      if (tag_valid !== 1'b1 || tag !== TAG_W'(k) || obs !== exp_obs()) begin
        tests_failed++;
        $display("FAIL fill_order: got valid=%b tag=%0d want valid=1 tag=%0d", tag_valid, tag, k);
      end
      cycle();
    end
    tests_run++;
    if (tag_valid !== 1'b0 || all_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_done: got valid=%b all_busy=%b want 0/1", tag_valid, all_busy);
    end
`ifdef NEWTAG_ISSUER_CNT_EN
    tests_run++;
    if (out_cnt !== NT) begin
      tests_failed++;
      $display("FAIL fill_cnt: got %0d want %0d", out_cnt, NT);
    end
`endif
  endtask

  task automatic test_retire_full();
    ret_valid = 1'b1;
    ret_tag = 3'd5;
    cycle();
    ret_valid = 1'b0;
    tests_run++;
    if (all_busy !== 1'b0 || tag_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL retire_free: got all_busy=%b valid=%b want 0/0", all_busy, tag_valid);
    end
    cycle();
    tests_run++;
    if (tag_valid !== 1'b1 || tag !== 3'd5 || all_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restage: got valid=%b tag=%0d all_busy=%b want 1/5/1", tag_valid, tag, all_busy);
    end
`ifdef NEWTAG_ISSUER_CNT_EN
    tests_run++;
    if (out_cnt !== NT - 1) begin
      tests_failed++;
      $display("FAIL restage_cnt: got %0d want %0d", out_cnt, NT - 1);
    end
`endif
    cycle();
    tests_run++;
    if (tag_valid !== 1'b0 || obs !== exp_obs()) begin
      tests_failed++;
      $display("FAIL rehandshake: got %h want %h", obs, exp_obs());
    end
`ifdef NEWTAG_ISSUER_CNT_EN
    tests_run++;
    if (out_cnt !== NT) begin
      tests_failed++;
      $display("FAIL rehandshake_cnt: got %0d want %0d", out_cnt, NT);
    end
`endif
  endtask

  task automatic test_round_robin();
    int exp_rr[5];
    exp_rr = '{4, 5, 6, 7, 1};
    do_reset();
    cycle();
    tag_ready = 1'b1;
    repeat (4) cycle();
    ret_valid = 1'b1;
    ret_tag = 3'd1;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (tag_valid !== 1'b1 || tag !== TAG_W'(exp_rr[k])) begin
        tests_failed++;
        $display("FAIL round_robin: got valid=%b tag=%0d want valid=1 tag=%0d", tag_valid, tag, exp_rr[k]);
      end
      cycle();
      ret_valid = 1'b0;
    end
  endtask

  task automatic test_stall();
    do_reset();
    cycle();
    tag_ready = 1'b1;
    repeat (2) cycle();
    tag_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ret_valid = (k == 4);
      ret_tag = '0;
      tests_run++;
      if (tag_valid !== 1'b1 || tag !== 3'd2 || err !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold: got valid=%b tag=%0d err=%b want 1/2/0", tag_valid, tag, err);
      end
      cycle();
    end
    ret_valid = 1'b0;
    tests_run++;
    if (obs !== exp_obs()) begin
      tests_failed++;
      $display("FAIL stall_model: got %h want %h", obs, exp_obs());
    end
  endtask

  task automatic test_err_free();
    ret_valid = 1'b1;
    ret_tag = 3'd6;
    cycle();
    ret_valid = 1'b0;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_free: got %b want 1", err);
    end
    tag_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ret_valid = (k == 3);
      ret_tag = 3'd2;
      cycle();
      tests_run++;
      if (err !== 1'b1 || obs !== exp_obs()) begin
        tests_failed++;
        $display("FAIL err_sticky: got %h want %h", obs, exp_obs());
      end
    end
    ret_valid = 1'b0;
  endtask

  task automatic test_err_staged();
    do_reset();
    cycle();
    tag_ready = 1'b1;
    ret_valid = 1'b1;
    ret_tag = '0;
    cycle();
    ret_valid = 1'b0;
    tests_run++;
    if (err !== 1'b1 || tag !== 3'd1 || obs !== exp_obs()) begin
      tests_failed++;
      $display("FAIL err_staged: got %h want %h", obs, exp_obs());
    end
`ifdef NEWTAG_ISSUER_CNT_EN
    tests_run++;
    if (out_cnt !== 1) begin
      tests_failed++;
      $display("FAIL err_staged_cnt: got %0d want 1", out_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle();
    tag_ready = 1'b1;
    ret_valid = 1'b1;
    ret_tag = 3'd7;
    cycle();
    ret_valid = 1'b0;
    repeat (2) cycle();
    tests_run++;
    if (tag !== 3'd3 || tag_valid !== 1'b1 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_async: got tag=%0d valid=%b err=%b want 3/1/1", tag, tag_valid, err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (tag_valid !== 1'b0 || all_busy !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%b all_busy=%b err=%b want 0/0/0", tag_valid, all_busy, err);
    end
    do_reset();
    tag_ready = 1'b1;
    cycle();
    tests_run++;
    if (tag_valid !== 1'b1 || tag !== 0) begin
      tests_failed++;
      $display("FAIL async_restart: got valid=%b tag=%0d want 1/0", tag_valid, tag);
    end
  endtask

  task automatic test_random();
    int outs[$];
    do_reset();
    for (int n = 0; n < 400; n++) begin
      tag_ready = ($urandom_range(0, 3) != 0);
      ret_valid = 1'b0;
      outs.delete();
      foreach (life[k]) if (life[k] == L_OUT) outs.push_back(k);
      if (outs.size() > 0 && $urandom_range(0, 2) == 0) begin
        ret_valid = 1'b1;
        ret_tag = TAG_W'(outs[$urandom_range(0, outs.size() - 1)]);
      end else if ($urandom_range(0, 49) == 0) begin
        ret_valid = 1'b1;
        ret_tag = TAG_W'($urandom_range(0, NT - 1));
      end
      cycle();
      tests_run++;
      if (obs !== exp_obs()) begin
        tests_failed++;
        $display("FAIL random_model: cycle %0d got %h want %h", n, obs, exp_obs());
      end
`ifdef NEWTAG_ISSUER_CNT_EN
      tests_run++;
      if (out_cnt !== (TAG_W+1)'(m_cnt)) begin
        tests_failed++;
        $display("FAIL random_cnt: cycle %0d got %0d want %0d", n, out_cnt, m_cnt);
      end
`endif
    end
    ret_valid = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    tag_ready = 1'b0;
    ret_valid = 1'b0;
    ret_tag = '0;
    test_reset();
    test_fill();
    test_retire_full();
    test_round_robin();
    test_stall();
    test_err_free();
    test_err_staged();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
